// File: rtl/piano_pkg.sv
// Shared constants, FSM encoding and helpers for the polyphonic tone mixer.
// Optional envelope feature is selected with the POLY_TONE_ENVELOPE_EN macro.
package piano_pkg;

   localparam real C4_HZ       = 261.63;
   localparam real SAMPLE_RATE = 48000.0;

   localparam int DEF_NUM_KEYS  = 17;
   localparam int DEF_PHASE_W   = 20;
   localparam int DEF_SAMPLE_W  = 12;
   localparam int DEF_OUT_W     = 8;
   localparam int DEF_MIX_SHIFT = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_EMIT  = 2'd2
   } state_t;

   // Equal-tempered semitone k above C4 as a phase increment; elaboration-time only.
   function automatic int calc_inc(input int k, input int phase_w);
      real r;
      r = C4_HZ * (2.0 ** (real'(k) / 12.0)) * (2.0 ** phase_w) / SAMPLE_RATE;
      return $rtoi(r + 0.5);
   endfunction

   function automatic int saturate(input int v, input int out_w);
      int hi;
      int lo;
      hi = (1 <<< (out_w - 1)) - 1;
      lo = -(1 <<< (out_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/key_inc_rom.sv
// Combinational key index to phase-increment lookup; indices past the last key read 0.
module key_inc_rom
   import piano_pkg::*;
#(
   parameter int NUM_KEYS = DEF_NUM_KEYS,
   parameter int PHASE_W  = DEF_PHASE_W,
   parameter int IDX_W    = $clog2(DEF_NUM_KEYS + 1)
) (
   input  logic [IDX_W-1:0]   idx,
   output logic [PHASE_W-1:0] inc
);

   logic [PHASE_W-1:0] rom_q [NUM_KEYS];

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rom
      localparam int INC_K = calc_inc(k, PHASE_W);
      assign rom_q[k] = PHASE_W'(INC_K);
   end

   always_comb begin
      inc = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (idx == IDX_W'(k)) inc = rom_q[k];
      end
   end

endmodule

// File: rtl/poly_tone_mixer.sv
// Time-multiplexed polyphonic triangle mixer: one voice per clock, one sweep per AC97 ready.
// Define POLY_TONE_ENVELOPE_EN for per-key attack/release envelopes (adds one pipeline stage).
module poly_tone_mixer
   import piano_pkg::*;
#(
   parameter  int NUM_KEYS  = DEF_NUM_KEYS,
   parameter  int PHASE_W   = DEF_PHASE_W,
   parameter  int SAMPLE_W  = DEF_SAMPLE_W,
   parameter  int OUT_W     = DEF_OUT_W,
   parameter  int MIX_SHIFT = DEF_MIX_SHIFT,
   localparam int CNT_W     = $clog2(NUM_KEYS + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_KEYS-1:0]     key_num,
   input  logic                    ready,
   output logic signed [OUT_W-1:0] pcm_data,
   output logic                    sample_valid,
   output logic                    busy,
   output logic                    overrun,
   output logic [CNT_W-1:0]        voice_count
);

   localparam int SUM_W = SAMPLE_W + CNT_W;
`ifdef POLY_TONE_ENVELOPE_EN
   localparam int LAST_IDX     = NUM_KEYS;
   localparam int ATTACK_STEP  = 16;
   localparam int RELEASE_STEP = 4;
`else
   localparam int LAST_IDX     = NUM_KEYS - 1;
`endif

   state_t                    state, state_nx;
   logic [NUM_KEYS-1:0]       key_lat;
   logic [CNT_W-1:0]          idx;
   logic [CNT_W-1:0]          count;
   logic signed [SUM_W-1:0]   sum;
   logic signed [SUM_W-1:0]   shifted;
   logic [PHASE_W-1:0]        phase [NUM_KEYS];
   logic [PHASE_W-1:0]        cur_phase;
   logic [PHASE_W-1:0]        inc;
   logic                      pressed;
   logic [SAMPLE_W-1:0]       u;
   logic signed [SAMPLE_W-1:0] tri_s;

   key_inc_rom #(.NUM_KEYS(NUM_KEYS), .PHASE_W(PHASE_W), .IDX_W(CNT_W)) u_rom (
      .idx (idx),
      .inc (inc)
   );

   always_comb begin
      cur_phase = '0;
      pressed   = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (idx == CNT_W'(k)) begin
            cur_phase = phase[k];
            pressed   = key_lat[k];
         end
      end
   end

   // Subtracting 2^(SAMPLE_W-1) from an unsigned SAMPLE_W value is an MSB flip.
   assign u       = cur_phase[PHASE_W-2 -: SAMPLE_W] ^ {SAMPLE_W{cur_phase[PHASE_W-1]}};
   assign tri_s   = {~u[SAMPLE_W-1], u[SAMPLE_W-2:0]};
   assign shifted = sum >>> MIX_SHIFT;

`ifdef POLY_TONE_ENVELOPE_EN
   logic [7:0]                   env [NUM_KEYS];
   logic [7:0]                   cur_env, env_nx;
   logic                         in_range;
   logic signed [SAMPLE_W-1:0]   p_tri;
   logic [7:0]                   p_env;
   logic                         p_act;
   logic signed [SAMPLE_W+8:0]   prod;

   always_comb begin
      cur_env  = '0;
      in_range = (idx < CNT_W'(NUM_KEYS));
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (idx == CNT_W'(k)) cur_env = env[k];
      end
      if (pressed)
         env_nx = (cur_env > 8'(255 - ATTACK_STEP)) ? 8'd255 : cur_env + 8'(ATTACK_STEP);
      else
         env_nx = (cur_env < 8'(RELEASE_STEP)) ? 8'd0 : cur_env - 8'(RELEASE_STEP);
   end

   assign prod = (SAMPLE_W+9)'(p_tri) * (SAMPLE_W+9)'($signed({1'b0, p_env}));
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (ready) state_nx = ST_SWEEP;
         ST_SWEEP: if (idx == CNT_W'(LAST_IDX)) state_nx = ST_EMIT;
         ST_EMIT:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_lat      <= '0;
         idx          <= '0;
         count        <= '0;
         sum          <= '0;
         pcm_data     <= '0;
         voice_count  <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         for (int k = 0; k < NUM_KEYS; k++) phase[k] <= '0;
`ifdef POLY_TONE_ENVELOPE_EN
         for (int k = 0; k < NUM_KEYS; k++) env[k] <= '0;
         p_tri <= '0;
         p_env <= '0;
         p_act <= 1'b0;
`endif
      end else begin
         sample_valid <= 1'b0;
         overrun      <= ready && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (ready) begin
                  key_lat <= key_num;
                  sum     <= '0;
                  count   <= '0;
                  idx     <= '0;
                  busy    <= 1'b1;
`ifdef POLY_TONE_ENVELOPE_EN
                  p_act   <= 1'b0;
`endif
               end
            end
            ST_SWEEP: begin
               idx <= idx + 1'b1;
`ifdef POLY_TONE_ENVELOPE_EN
               // Stage 1 updates envelope/phase; stage 2 accumulates the previous key.
               p_act <= 1'b0;
               if (in_range) begin
                  p_tri <= tri_s;
                  p_env <= env_nx;
                  p_act <= (env_nx != 8'd0);
                  for (int k = 0; k < NUM_KEYS; k++) begin
                     if (idx == CNT_W'(k)) begin
                        env[k]   <= env_nx;
                        phase[k] <= (env_nx != 8'd0) ? cur_phase + inc : '0;
                     end
                  end
               end
               if (p_act) begin
                  sum   <= sum + SUM_W'(prod >>> 8);
                  count <= count + 1'b1;
               end
`else
               for (int k = 0; k < NUM_KEYS; k++) begin
                  if (idx == CNT_W'(k)) phase[k] <= pressed ? cur_phase + inc : '0;
               end
               if (pressed) begin
                  sum   <= sum + {{CNT_W{tri_s[SAMPLE_W-1]}}, tri_s};
                  count <= count + 1'b1;
               end
`endif
            end
            ST_EMIT: begin
               pcm_data     <= OUT_W'(saturate(int'(shifted), OUT_W));
               voice_count  <= count;
               sample_valid <= 1'b1;
               busy         <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_tone_mixer.sv
// Directed bench for poly_tone_mixer (default build, 17 keys, 20-bit phase, 8-bit PCM).
module tb_poly_tone_mixer;

   logic              clock = 1'b0;
   logic              reset;
   logic [16:0]       key_num;
   logic              ready;
   logic signed [7:0] pcm_data;
   logic              sample_valid;
   logic              busy;
   logic              overrun;
   logic [4:0]        voice_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   poly_tone_mixer dut (
      .clock        (clock),
      .reset        (reset),
      .key_num      (key_num),
      .ready        (ready),
      .pcm_data     (pcm_data),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun),
      .voice_count  (voice_count)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse ready for one edge, then wait (bounded) for the sample_valid pulse.
   task automatic do_sample(input string tag, input int exp_pcm, input int exp_vc);
      int n;
      bit got;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk({tag, "_busy_hi"}, busy, 1);
      n = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         tick();
         n++;
         if (sample_valid) got = 1'b1;
      end
      chk({tag, "_latency"}, got ? n : -1, 18);
      chk({tag, "_pcm"}, $signed(pcm_data), exp_pcm);
      chk({tag, "_vc"}, voice_count, exp_vc);
      chk({tag, "_busy_lo"}, busy, 0);
      tick();
      chk({tag, "_sv_pulse"}, sample_valid, 0);
   endtask

   initial begin
      int svc;
      int ovc;
      int lat;
      int n;

      reset   = 1'b1;
      ready   = 1'b0;
      key_num = '0;
      #12;
      chk("rst_pcm", $signed(pcm_data), 0);
      chk("rst_sv", sample_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_vc", voice_count, 0);
      tick();
      reset = 1'b0;
      tick();

      // Single key from trough: tri -2048, then phase 5715 and 11430.
      key_num = 17'h00001;
      do_sample("k1a", -64, 1);
      repeat (30) tick();
      chk("k1a_hold", $signed(pcm_data), -64);
      do_sample("k1b", -63, 1);
      repeat (10) tick();
      do_sample("k1c", -62, 1);
      repeat (5) tick();

      // Asynchronous reset in the middle of a sweep.
      ready = 1'b1;
      tick();
      ready = 1'b0;
      repeat (5) tick();
      chk("mid_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_pcm", $signed(pcm_data), 0);
      chk("arst_vc", voice_count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_sv", sample_valid, 0);
      svc = 0;
      repeat (3) begin
         tick();
         if (sample_valid) svc++;
      end
      reset = 1'b0;
      repeat (25) begin
         tick();
         if (sample_valid) svc++;
      end
      chk("arst_no_sv", svc, 0);
      do_sample("arst_next", -64, 1);
      repeat (5) tick();

      key_num = 17'h00000;
      do_sample("silence", 0, 0);
      repeat (5) tick();

      // All voices at the trough: -2048*17 = -34816, >>>5 = -1088, clamps to -128.
      key_num = 17'h1FFFF;
      do_sample("sat", -128, 17);
      repeat (5) tick();

      // Second ready five cycles into a sweep is dropped with one overrun pulse.
      key_num = 17'h00000;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      svc = 0;
      ovc = 0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (sample_valid) begin
            svc++;
            if (lat < 0) lat = i;
         end
         if (overrun) ovc++;
         ready = (i == 5);
      end
      ready = 1'b0;
      chk("ovr_pulses", ovc, 1);
      chk("ovr_samples", svc, 1);
      chk("ovr_latency", lat, 18);
      chk("ovr_pcm", $signed(pcm_data), 0);
      repeat (5) tick();

      // key_num drops mid-sweep; the latched mask still plays key 0 this sample.
      key_num = 17'h00001;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n = 0;
      lat = -1;
      while (lat < 0 && n < 60) begin
         tick();
         n++;
         if (n == 3) key_num = 17'h00000;
         if (sample_valid) lat = n;
      end
      chk("chg_latency", lat, 18);
      chk("chg_pcm", $signed(pcm_data), -64);
      chk("chg_vc", voice_count, 1);
      repeat (5) tick();
      do_sample("chg_next", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_tone_mixer.md
Name: poly_tone_mixer

Overview:
- Polyphonic successor to the single-tone key player, parametrised in key count and widths.
- Per key: phase accumulator plus triangle voice. All pressed keys are mixed into one saturated signed PCM sample for the AC97 path.
- Voices are processed time-multiplexed, one key per clock, in a sweep started by the AC97 sample-ready strobe (48 kHz).
- Sits between key detection (key_num) and the AC97 output data register.

Parameters:
- NUM_KEYS, 17: number of keys/voices; one bit per key in key_num.
- PHASE_W, 20: phase accumulator width.
- SAMPLE_W, 12: per-voice triangle sample width (signed).
- OUT_W, 8: output PCM width (signed).
- MIX_SHIFT, 5: arithmetic right shift applied to the voice sum before saturation.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- key_num, input, NUM_KEYS: bit k high = key k pressed.
- ready, input, 1: one-cycle sample strobe from the AC97 block.
- pcm_data, output, OUT_W: signed mixed sample to the AC97 path.
- sample_valid, output, 1: one-cycle pulse when pcm_data updates.
- busy, output, 1: high while a sweep is in progress.
- overrun, output, 1: one-cycle pulse when ready arrives while busy.
- voice_count, output, clog2(NUM_KEYS+1): number of voices that contributed to the last sample.

Behaviour:
- Reset (async):
  - pcm_data=0, sample_valid=0, busy=0, overrun=0, voice_count=0.
  - All phase accumulators 0; FSM to IDLE.
- FSM states: IDLE, SWEEP, EMIT.
- IDLE:
  - On ready: latch key_num into key_lat, clear accumulator sum and counter, set idx=0, busy=1, go to SWEEP.
- SWEEP: one key per cycle, idx = 0..NUM_KEYS-1.
  - Increment inc[idx] comes from key_inc_rom.
  - Voice sample is computed from the phase before the increment.
  - Triangle: u = phase[PHASE_W-2 -: SAMPLE_W], inverted bitwise when phase[PHASE_W-1]=1; tri = u - 2^(SAMPLE_W-1).
  - Key pressed in key_lat: sum += tri, count++, phase[idx] += inc[idx] (mod 2^PHASE_W).
  - Key not pressed: phase[idx] := 0, so the next press starts at the waveform trough. Nothing is added to sum.
  - After idx = NUM_KEYS-1, go to EMIT.
- EMIT:
  - pcm_data := saturate(sum >>> MIX_SHIFT) to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - voice_count := count; sample_valid=1 for this cycle; busy=0; go to IDLE.
- Latency: ready at cycle 0 → sample_valid and new pcm_data at cycle NUM_KEYS+1.
- sum width: SAMPLE_W + clog2(NUM_KEYS+1), signed. It never overflows internally.
- No key pressed: sum=0, so pcm_data=0 exactly.
- ready while busy (SWEEP or EMIT):
  - Ignored; overrun pulses for 1 cycle.
  - The current sweep completes unchanged.
  - The system requires NUM_KEYS+2 < cycles per sample period (about 560 at 27 MHz).
- key_num changes mid-sweep: no effect until the next ready (key_lat is used).
- ready in EMIT: treated as busy (overrun pulse, dropped).
- Reset mid-sweep: everything returns to reset values immediately. No sample_valid is emitted.
- pcm_data holds between sample_valid pulses.

Optional Feature:
- Macro: POLY_TONE_ENVELOPE_EN.
- When defined:
  - Each key has an 8-bit envelope env[k] with reset value 0.
  - Each sweep: pressed → env += ATTACK_STEP (localparam 16), saturating at 255. Released → env -= RELEASE_STEP (localparam 4), saturating at 0.
  - A voice contributes (tri*env)>>>8 and counts toward voice_count while env>0 after the update.
  - Its phase keeps advancing while env>0. The phase resets to 0 only when env==0 and the key is released.
  - Adds one pipeline stage per key (multiply). Latency becomes NUM_KEYS+2.
- When undefined: behaviour exactly as above, with no envelope state.

Decomposition:
- Shared package/include piano_pkg holds:
  - Base frequency constant C4 = 261.63 Hz and sample rate 48000.
  - Default widths.
  - The saturate function.
  - FSM state encodings.
- Sub-module key_inc_rom:
  - Combinational index → increment lookup.
  - inc[k] = round(261.63·2^(k/12)·2^PHASE_W/48000), e.g. inc[0]=5715 for PHASE_W=20.

Test Plan:
- Reset: assert reset mid-sweep → all outputs 0 asynchronously, no sample_valid; the next ready after release produces a normal sample.
- Single key: key_num=17'h00001, pulse ready twice, far apart → sample_valid at cycle 18 after each ready; pcm_data=-64, then -63; voice_count=1; phase[0]=11430 after the second sweep.
- Silence: key_num=0, ready → pcm_data=0, voice_count=0, sample_valid pulse.
- Saturation: key_num=17'h1FFFF from reset, ready → sum=-34816 → pcm_data=-128 (8'h80), voice_count=17.
- Overrun: ready, then ready again 5 cycles later → overrun pulse once; exactly one sample_valid, at cycle 18 after the first ready.
- Mid-sweep key change: key_num changes from 1 to 0 at cycle 3 of a sweep → that sample still shows key 0 active (voice_count=1); the next sample gives pcm_data=0.
